// File: rtl/time_counter_if.sv
// Request/status bundle between a controller and the seconds timer.
// Optional remainingSeconds signal exists only when TIME_COUNTER_REMAINING_EN is defined.
interface time_counter_if #(
  parameter int SEC_W = 7
);
  logic [SEC_W-1:0] secondsToCount;
  logic             startCounting;
  logic             timeFinished;
  logic             busy;
  logic [SEC_W-1:0] elapsedSeconds;
`ifdef TIME_COUNTER_REMAINING_EN
  logic [SEC_W-1:0] remainingSeconds;
`endif

  // Level-based protocol, no valid/ready: startCounting is sampled on every
  // rising edge and acts as a (re)start for as long as it is held high;
  // secondsToCount is only meaningful on those edges. Status outputs are
  // registered levels that the controller may sample at any edge.
`ifdef TIME_COUNTER_REMAINING_EN
  modport master (
    output secondsToCount, startCounting,
    input  timeFinished, busy, elapsedSeconds, remainingSeconds
  );
  modport slave (
    input  secondsToCount, startCounting,
    output timeFinished, busy, elapsedSeconds, remainingSeconds
  );
`else
  modport master (
    output secondsToCount, startCounting,
    input  timeFinished, busy, elapsedSeconds
  );
  modport slave (
    input  secondsToCount, startCounting,
    output timeFinished, busy, elapsedSeconds
  );
`endif
endinterface

// File: rtl/time_counter.sv
// Programmable seconds timer: divides CLK into one-second ticks and flags when the requested count elapses.
// Optional feature macro: TIME_COUNTER_REMAINING_EN adds a registered remainingSeconds output.
module time_counter #(
  parameter int CYCLES_PER_SECOND = 10000,
  parameter int SEC_W             = 7
) (
  input  logic           CLK,
  input  logic           RST,
  time_counter_if.slave  bus,
  output logic [1:0]     dbg_state_o
);

  localparam int CNT_W = (CYCLES_PER_SECOND > 1) ? $clog2(CYCLES_PER_SECOND) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CYCLES_PER_SECOND - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEC_W-1:0] elapsed_q, elapsed_d;
  logic [SEC_W-1:0] target_q, target_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic [SEC_W-1:0] sec_inc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      elapsed_q <= '0;
      target_q  <= '0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      target_q  <= target_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  // A start request overrides whatever the current state would have done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    elapsed_d = elapsed_q;
    target_d  = target_q;
    fin_d     = fin_q;
    sec_inc   = elapsed_q + SEC_W'(1);
    if (bus.startCounting) begin
      target_d  = bus.secondsToCount;
      cnt_d     = '0;
      elapsed_d = '0;
      fin_d     = 1'b0;
      state_d   = (bus.secondsToCount == '0) ? DONE : COUNTING;
    end else begin
      case (state_q)
        COUNTING: begin
          if (cnt_q == TERM_CNT) begin
            cnt_d     = '0;
            elapsed_d = sec_inc;
            if (sec_inc == target_q) begin
              state_d = DONE;
              fin_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Also covers a zero target: finished appears one edge after the start edge.
        DONE:    fin_d = 1'b1;
        default: ;
      endcase
    end
    busy_d = (state_d == COUNTING);
  end

  assign bus.timeFinished   = fin_q;
  assign bus.busy           = busy_q;
  assign bus.elapsedSeconds = elapsed_q;
  assign dbg_state_o        = state_q;

`ifdef TIME_COUNTER_REMAINING_EN
  logic [SEC_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = '0;
    if (state_d == COUNTING) begin
      rem_d = target_d - elapsed_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign bus.remainingSeconds = rem_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter with a short second (10 cycles): directed table, corner sequences, random restarts.
// Build with TIME_COUNTER_REMAINING_EN defined to also check remainingSeconds.
module tb_time_counter;
  localparam int CPS   = 10;
  localparam int SEC_W = 7;
  localparam int QW    = 2 * SEC_W + 2;

  // clock / reset
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] dbg_state;
  always #5 CLK = ~CLK;

  time_counter_if #(.SEC_W(SEC_W)) bus ();

  time_counter #(
    .CYCLES_PER_SECOND(CPS),
    .SEC_W(SEC_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // reference model: edges since the last start, and what they imply
  bit m_started    = 1'b0;
  bit m_last_start = 1'b0;
  int m_n          = 0;
  int m_tgt        = 0;
  logic [QW-1:0] exp_q[$];

  task automatic model_reset();
    m_started    = 1'b0;
    m_last_start = 1'b0;
    m_n          = 0;
    m_tgt        = 0;
  endtask

  task automatic model_edge(input bit st, input int sec);
    int e, rem;
    bit f, b;
    if (RST) begin
      model_reset();
    end else if (st) begin
      m_started    = 1'b1;
      m_last_start = 1'b1;
      m_tgt        = sec;
      m_n          = 0;
    end else begin
      m_last_start = 1'b0;
      if (m_started && m_n < 1000000) m_n++;
    end
    if (!m_started) begin
      e = 0; f = 1'b0; b = 1'b0;
    end else if (m_last_start) begin
      e = 0; f = 1'b0; b = (m_tgt != 0);
    end else begin
      f = (m_n >= m_tgt * CPS);
      e = (m_n / CPS < m_tgt) ? m_n / CPS : m_tgt;
      b = !f;
    end
    rem = m_started ? (m_tgt - e) : 0;
    exp_q.push_back({SEC_W'(rem), f, b, SEC_W'(e)});
  endtask

  task automatic compare_model();
    logic [QW-1:0] x;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard empty");
      return;
    end
    x = exp_q.pop_front();
    check("model elapsed", int'(bus.elapsedSeconds), int'(x[SEC_W-1:0]));
    check("model busy", int'(bus.busy), int'(x[SEC_W]));
    check("model finished", int'(bus.timeFinished), int'(x[SEC_W+1]));
`ifdef TIME_COUNTER_REMAINING_EN
    check("model remaining", int'(bus.remainingSeconds), int'(x[QW-1:SEC_W+2]));
`endif
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 after rising
  task automatic step(input bit st, input int sec);
    @(negedge CLK);
    bus.startCounting  = st;
    bus.secondsToCount = SEC_W'(sec);
    @(posedge CLK);
    #1;
    model_edge(st, sec);
    compare_model();
  endtask

  typedef struct {
    bit start;
    int sec;
    int cycles;
    int exp_e;
    bit exp_f;
    bit exp_b;
  } vec_t;
  vec_t vecs[$];

  initial begin
    bus.startCounting  = 1'b0;
    bus.secondsToCount = '0;

    vecs.push_back('{1'b1, 5, 1,  0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 5, 9,  0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 5, 1,  1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 5, 39, 4, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 5, 1,  5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 9, 20, 5, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 0, 1,  0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 0, 1,  0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 7, 30, 0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 7, 10, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 7, 20, 3, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 2, 1,  0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 2, 19, 1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 2, 1,  2, 1'b1, 1'b0});

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset elapsed", int'(bus.elapsedSeconds), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset finished", int'(bus.timeFinished), 0);
`ifdef TIME_COUNTER_REMAINING_EN
    check("reset remaining", int'(bus.remainingSeconds), 0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // directed table
    for (int r = 0; r < vecs.size(); r++) begin
      for (int k = 0; k < vecs[r].cycles; k++) step(vecs[r].start, vecs[r].sec);
      check($sformatf("row%0d elapsed", r), int'(bus.elapsedSeconds), vecs[r].exp_e);
      check($sformatf("row%0d finished", r), int'(bus.timeFinished), int'(vecs[r].exp_f));
      check($sformatf("row%0d busy", r), int'(bus.busy), int'(vecs[r].exp_b));
    end

    // remaining count follows each tick of a 4 s run
    step(1'b1, 4);
    for (int s = 4; s >= 0; s--) begin
`ifdef TIME_COUNTER_REMAINING_EN
      check($sformatf("remaining at %0d", s), int'(bus.remainingSeconds), s);
`endif
      check($sformatf("elapsed at rem %0d", s), int'(bus.elapsedSeconds), 4 - s);
      if (s > 0) repeat (CPS) step(1'b0, 4);
    end

    // asynchronous reset mid-count, then stay idle
    step(1'b1, 5);
    repeat (23) step(1'b0, 5);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async rst finished", int'(bus.timeFinished), 0);
    check("async rst busy", int'(bus.busy), 0);
    check("async rst elapsed", int'(bus.elapsedSeconds), 0);
    model_reset();
    repeat (2) step(1'b0, 5);
    @(negedge CLK);
    RST = 1'b0;
    repeat (15) step(1'b0, 5);
    check("idle after rst busy", int'(bus.busy), 0);
    check("idle after rst elapsed", int'(bus.elapsedSeconds), 0);

    // random restarts and targets against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
